// File: rtl/jpeg_pkg.sv
// jpeg_pkg: constants and symbol types shared by the JPEG entropy path.
package jpeg_pkg;
  localparam int BLOCK_LEN = 64;
  localparam int ZRL_RUN = 15;
  localparam int RUN_W = 4;
  localparam int SIZE_W = 4;
  localparam int COEF_BITS = 12;
  typedef enum logic [2:0] {IDLE, RD, CAP, DEC, EMIT, FIN} rle_state_t;
  typedef struct packed {
    logic dc;
    logic [RUN_W-1:0] run;
    logic [SIZE_W-1:0] size;
    logic [COEF_BITS-1:0] amp;
  } sym_t;
endpackage

// File: rtl/rle_scan_if.sv
// rle_scan_if: zig-zag RAM read port plus the symbol stream toward the Huffman coder.
interface rle_scan_if import jpeg_pkg::*; #(parameter int COEF_W = COEF_BITS);
  logic zig_zag_rd_en;
  logic [5:0] zig_zag_rd_addr;
  logic [COEF_W-1:0] zig_zag_rd_data;
  logic sym_valid, sym_ready, sym_dc;
  logic [RUN_W-1:0] sym_run;
  logic [SIZE_W-1:0] sym_size;
  logic [COEF_W-1:0] sym_amp;
  modport master (
    output zig_zag_rd_en, zig_zag_rd_addr, sym_valid, sym_dc, sym_run, sym_size, sym_amp,
    input  zig_zag_rd_data, sym_ready
  );
  modport slave (
    input  zig_zag_rd_en, zig_zag_rd_addr, sym_valid, sym_dc, sym_run, sym_size, sym_amp,
    output zig_zag_rd_data, sym_ready
  );
endinterface

// File: rtl/rle_size_amp.sv
// rle_size_amp: JPEG magnitude category and amplitude bits of a signed value.
module rle_size_amp import jpeg_pkg::*; #(parameter int COEF_W = COEF_BITS) (
  input  logic signed [COEF_W:0] val,
  output logic [SIZE_W-1:0] size,
  output logic [COEF_W-1:0] amp
);
  logic [COEF_W:0] mag;
  logic [COEF_W-1:0] amp_full;
  always_comb begin
    mag = val[COEF_W] ? -val : val;
    size = '0;
    for (int i = 0; i <= COEF_W; i++) if (mag[i]) size = SIZE_W'(i + 1);
  end
  // negative values carry (value-1), i.e. the one's complement of |value|
  assign amp_full = COEF_W'(val[COEF_W] ? val - (COEF_W+1)'(1) : val);
  assign amp = amp_full & ({COEF_W{1'b1}} >> (COEF_W - int'(size)));
endmodule

// File: rtl/rle_scan.sv
// rle_scan: turns one zig-zag ordered 8x8 block into JPEG DC/AC/ZRL/EOB symbols.
module rle_scan import jpeg_pkg::*; #(parameter int COEF_W = COEF_BITS) (
  input  logic clk_in,
  input  logic rst,
  input  logic huffman_start,
  input  logic eof_in,
  input  logic halt,
  output logic block_done,
  output logic eof_out,
  rle_scan_if.master bus
);
  localparam logic [5:0] LAST = 6'(BLOCK_LEN - 1);
  rle_state_t state;
  logic [5:0] idx, run;
  logic signed [COEF_W-1:0] coef_q, prev_dc;
  logic eof_q, pend, pend_eof, zrl, valid;
  logic signed [COEF_W:0] val;
  logic [SIZE_W-1:0] size;
  logic [COEF_W-1:0] amp;
  sym_t sym;
  // DC uses the difference to the previous block, AC the coefficient itself
  assign val = {coef_q[COEF_W-1], coef_q} - (idx == '0 ? {prev_dc[COEF_W-1], prev_dc} : '0);
  assign zrl = !sym.dc && sym.size == '0 && sym.run == RUN_W'(ZRL_RUN);
  assign bus.zig_zag_rd_en = state == RD && !halt;
  assign bus.zig_zag_rd_addr = idx;
  assign bus.sym_valid = valid;
  assign {bus.sym_dc, bus.sym_run, bus.sym_size, bus.sym_amp} = sym;
  rle_size_amp #(.COEF_W(COEF_W)) u_size_amp (.val(val), .size(size), .amp(amp));
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx <= '0;
      run <= '0;
      coef_q <= '0;
      prev_dc <= '0;
      eof_q <= 1'b0;
      pend <= 1'b0;
      pend_eof <= 1'b0;
      sym <= '0;
      valid <= 1'b0;
      block_done <= 1'b0;
      eof_out <= 1'b0;
    end else begin
      block_done <= 1'b0;
      eof_out <= 1'b0;
      if (huffman_start && state != IDLE && !pend) begin
        pend <= 1'b1;
        pend_eof <= eof_in;
      end
      case (state)
        IDLE: if (pend || huffman_start) begin
          eof_q <= pend ? pend_eof : eof_in;
          pend <= pend && huffman_start;
          pend_eof <= eof_in;
          idx <= '0;
          run <= '0;
          state <= RD;
        end
        RD: state <= halt ? RD : CAP;
        CAP: begin
          coef_q <= bus.zig_zag_rd_data;
          state <= DEC;
        end
        DEC: if (idx != '0 && coef_q == '0 && idx != LAST) begin
          run <= run + 6'd1;
          idx <= idx + 6'd1;
          state <= RD;
        end else begin
          valid <= 1'b1;
          state <= EMIT;
          if (idx == '0) begin
            prev_dc <= coef_q;
            sym <= '{1'b1, '0, size, amp};
          end else if (coef_q == '0) sym <= '0;
          else if (run >= 6'd16) begin
            sym <= '{1'b0, RUN_W'(ZRL_RUN), '0, '0};
            run <= run - 6'd16;
          end else begin
            sym <= '{1'b0, run[RUN_W-1:0], size, amp};
            run <= '0;
          end
        end
        // EOB only ever sits at the last index, so idx==LAST alone ends the block
        EMIT: if (bus.sym_ready) begin
          valid <= 1'b0;
          if (zrl) state <= DEC;
          else if (idx == LAST) begin
            block_done <= 1'b1;
            eof_out <= eof_q;
            state <= FIN;
          end else begin
            idx <= idx + 6'd1;
            state <= RD;
          end
        end
        FIN: begin
          if (eof_q) prev_dc <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rle_scan.sv
// tb_rle_scan: directed checks of rle_scan symbol output, timing, halt, backpressure and reset.
module tb_rle_scan;
  logic clk_in = 1'b0, rst = 1'b1, huffman_start = 1'b0, eof_in = 1'b0, halt = 1'b0;
  logic block_done, eof_out;
  logic signed [11:0] mem [64];
  int n_assert = 0, n_fail = 0;
  rle_scan_if #(.COEF_W(12)) bus ();
  rle_scan #(.COEF_W(12)) dut (
    .clk_in(clk_in), .rst(rst), .huffman_start(huffman_start), .eof_in(eof_in),
    .halt(halt), .block_done(block_done), .eof_out(eof_out), .bus(bus)
  );
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) if (bus.zig_zag_rd_en) bus.zig_zag_rd_data <= mem[bus.zig_zag_rd_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_sym(input string tag, input bit bp, input logic d,
                            input logic [3:0] r, input logic [3:0] s, input logic [11:0] a);
    bit got = 1'b0;
    for (int k = 0; k < 600 && !got; k++) begin
      @(negedge clk_in);
      if (bp) bus.sym_ready = 1'($urandom_range(0, 1));
      if (bus.sym_valid) begin
        check(tag, {bus.sym_dc, bus.sym_run, bus.sym_size, bus.sym_amp}, {d, r, s, a});
        got = bus.sym_ready;
      end
    end
    if (!got) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s: observed no accepted symbol expected one", tag);
    end
  endtask

  task automatic expect_done(input string tag, input logic e);
    @(negedge clk_in);
    check(tag, {block_done, eof_out, bus.sym_valid}, {1'b1, e, 1'b0});
    @(negedge clk_in);
    check({tag, "_pulse"}, {block_done, eof_out}, 2'b00);
  endtask

  task automatic clear_mem(input logic signed [11:0] dc);
    foreach (mem[i]) mem[i] = '0;
    mem[0] = dc;
  endtask

  task automatic start(input logic e);
    @(negedge clk_in);
    huffman_start = 1'b1;
    eof_in = e;
    @(negedge clk_in);
    huffman_start = 1'b0;
    eof_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.sym_ready = 1'b1;
    clear_mem(12'sd0);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk_in);
    check("reset_outputs", {bus.zig_zag_rd_en, bus.zig_zag_rd_addr, bus.sym_valid, bus.sym_dc,
          bus.sym_run, bus.sym_size, bus.sym_amp, block_done, eof_out}, 32'd0);
    rst = 1'b1;
    // DC-only block against prev_dc 0
    clear_mem(12'sd5);
    start(1'b0);
    check("rd_latency", {bus.zig_zag_rd_en, bus.zig_zag_rd_addr}, {1'b1, 6'd0});
    expect_sym("b1_dc", 0, 1'b1, 4'd0, 4'd3, 12'h005);
    expect_sym("b1_eob", 0, 1'b0, 4'd0, 4'd0, 12'h000);
    expect_done("b1_done", 1'b0);
    // diff 2-5 = -3
    clear_mem(12'sd2);
    start(1'b0);
    expect_sym("b2_dc", 0, 1'b1, 4'd0, 4'd2, 12'h000);
    expect_sym("b2_eob", 0, 1'b0, 4'd0, 4'd0, 12'h000);
    expect_done("b2_done", 1'b0);
    // eof block: diff -6-2 = -8
    clear_mem(-12'sd6);
    start(1'b1);
    expect_sym("b3_dc", 0, 1'b1, 4'd0, 4'd4, 12'h007);
    expect_sym("b3_eob", 0, 1'b0, 4'd0, 4'd0, 12'h000);
    expect_done("b3_done", 1'b1);
    // after eof prev_dc is 0; AC run of 18 splits into ZRL + run 2
    clear_mem(12'sd3);
    mem[1] = -12'sd1;
    mem[20] = 12'sd7;
    start(1'b0);
    expect_sym("b4_dc", 0, 1'b1, 4'd0, 4'd2, 12'h003);
    expect_sym("b4_ac1", 0, 1'b0, 4'd0, 4'd1, 12'h000);
    expect_sym("b4_zrl", 0, 1'b0, 4'd15, 4'd0, 12'h000);
    expect_sym("b4_ac20", 0, 1'b0, 4'd2, 4'd3, 12'h007);
    expect_sym("b4_eob", 0, 1'b0, 4'd0, 4'd0, 12'h000);
    expect_done("b4_done", 1'b0);
    // nonzero last coefficient: three ZRLs, no EOB
    clear_mem(12'sd3);
    mem[63] = 12'sd1;
    start(1'b0);
    expect_sym("b5_dc", 0, 1'b1, 4'd0, 4'd0, 12'h000);
    for (int i = 0; i < 3; i++) expect_sym("b5_zrl", 0, 1'b0, 4'd15, 4'd0, 12'h000);
    expect_sym("b5_ac63", 0, 1'b0, 4'd14, 4'd1, 12'h001);
    expect_done("b5_done", 1'b0);
    // halt held for four RD cycles
    clear_mem(12'sd5);
    @(negedge clk_in);
    huffman_start = 1'b1;
    halt = 1'b1;
    @(negedge clk_in);
    huffman_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk_in);
      check("halt_rd", {bus.zig_zag_rd_en, bus.zig_zag_rd_addr}, 32'd0);
    end
    halt = 1'b0;
    #1 check("halt_release", {bus.zig_zag_rd_en, bus.zig_zag_rd_addr}, {1'b1, 6'd0});
    expect_sym("b6_dc", 0, 1'b1, 4'd0, 4'd2, 12'h002);
    expect_sym("b6_eob", 0, 1'b0, 4'd0, 4'd0, 12'h000);
    expect_done("b6_done", 1'b0);
    // random backpressure, plus an eof start arriving mid-block
    clear_mem(12'sd1);
    mem[1] = -12'sd1;
    mem[20] = 12'sd7;
    start(1'b0);
    start(1'b1);
    expect_sym("b7_dc", 1, 1'b1, 4'd0, 4'd3, 12'h003);
    expect_sym("b7_ac1", 1, 1'b0, 4'd0, 4'd1, 12'h000);
    expect_sym("b7_zrl", 1, 1'b0, 4'd15, 4'd0, 12'h000);
    expect_sym("b7_ac20", 1, 1'b0, 4'd2, 4'd3, 12'h007);
    expect_sym("b7_eob", 1, 1'b0, 4'd0, 4'd0, 12'h000);
    expect_done("b7_done", 1'b0);
    expect_sym("b7p_dc", 1, 1'b1, 4'd0, 4'd0, 12'h000);
    expect_sym("b7p_ac1", 1, 1'b0, 4'd0, 4'd1, 12'h000);
    expect_sym("b7p_zrl", 1, 1'b0, 4'd15, 4'd0, 12'h000);
    expect_sym("b7p_ac20", 1, 1'b0, 4'd2, 4'd3, 12'h007);
    expect_sym("b7p_eob", 1, 1'b0, 4'd0, 4'd0, 12'h000);
    expect_done("b7p_done", 1'b1);
    // reset while a DC symbol is stalled
    bus.sym_ready = 1'b0;
    clear_mem(12'sd4);
    start(1'b0);
    repeat (8) @(negedge clk_in);
    check("stall_dc", {bus.sym_valid, bus.sym_dc, bus.sym_run, bus.sym_size, bus.sym_amp},
          {1'b1, 1'b1, 4'd0, 4'd3, 12'h004});
    rst = 1'b0;
    #1 check("midblock_reset", {bus.zig_zag_rd_en, bus.sym_valid, bus.sym_dc, bus.sym_run,
             bus.sym_size, bus.sym_amp, block_done, eof_out}, 32'd0);
    @(negedge clk_in);
    rst = 1'b1;
    bus.sym_ready = 1'b1;
    start(1'b0);
    expect_sym("b9_dc", 0, 1'b1, 4'd0, 4'd3, 12'h004);
    expect_sym("b9_eob", 0, 1'b0, 4'd0, 4'd0, 12'h000);
    expect_done("b9_done", 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/rle_scan.md
# rle_scan

Entropy-preparation stage directly downstream of the zig-zag buffer. It sequentially reads one 8x8 block of quantised coefficients, which the zig-zag RAM holds in zig-zag order at addresses 0..63. It converts them into JPEG baseline symbols: a DC difference, AC (run,size,amplitude) symbols, ZRL and EOB. Symbols go to the Huffman coder over a valid/ready handshake. The block respects the zig-zag write `halt` and propagates end-of-frame.

## Interface
Parameters:
- COEF_W, 12: coefficient width, two's complement. Legal range is ±(2^(COEF_W-1)-1).

Ports:
- clk_in  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- huffman_start  in  1  one-cycle pulse: a complete block is in the zig-zag RAM.
- eof_in  in  1  pulse coincident with `huffman_start`: this block is the last of the frame.
- halt  in  1  zig-zag RAM write in progress; reads are forbidden this cycle.
- zig_zag_rd_en  out  1  RAM read strobe.
- zig_zag_rd_addr  out  6  RAM read address.
- zig_zag_rd_data  in  COEF_W  RAM data, valid the cycle after `zig_zag_rd_en`.
- sym_valid  out  1  symbol present.
- sym_ready  in  1  consumer accepts when high with `sym_valid`.
- sym_dc  out  1  symbol is the DC difference.
- sym_run  out  4  zero run (AC only).
- sym_size  out  4  magnitude category; 0 for EOB/ZRL.
- sym_amp  out  COEF_W  amplitude bits, LSB-aligned, upper bits zero.
- block_done  out  1  one-cycle pulse after the last symbol of a block is accepted.
- eof_out  out  1  one-cycle pulse with `block_done` of a frame's last block.

## Operation
- FSM states: IDLE, RD, CAP, DEC, EMIT, FIN.
- IDLE: wait for `huffman_start` (or the pending start). Latch `eof_in`. Set idx=0, run=0. Go to RD.
- RD:
  - `zig_zag_rd_en` = ~halt (combinational); `zig_zag_rd_addr` = idx.
  - If `halt`, stay in RD; otherwise go to CAP.
- CAP: coef_q <= `zig_zag_rd_data`. Go to DEC.
- DEC, idx==0 (DC):
  - diff = coef_q − prev_dc, computed at COEF_W+1 bits.
  - prev_dc <= coef_q.
  - Load a DC symbol with run=0. Go to EMIT.
- DEC, idx>0 (AC):
  - coef_q==0 and idx<63: run++, idx++, go to RD.
  - coef_q==0 and idx==63: load EOB (run 0, size 0). Go to EMIT.
  - coef_q!=0 and run≥16: load ZRL (run 15, size 0), run −= 16, return to DEC after acceptance.
  - coef_q!=0 and run<16: load (run, size, amp), run=0. Go to EMIT.
- EMIT:
  - Hold `sym_valid` and all symbol fields stable until `sym_ready`.
  - On acceptance:
    - ZRL: back to DEC.
    - EOB, or a nonzero symbol at idx==63: go to FIN.
    - Otherwise: idx++, go to RD.
- FIN: pulse `block_done`, plus `eof_out` if eof was latched. An eof block clears prev_dc to 0. Go to IDLE.
- size = bit length of |value|; 0 only for value 0. A DC diff can reach size COEF_W.
- amp = value if value>0, else (value−1); the low `size` bits are kept.
- EOB is never preceded by ZRLs; trailing zeros produce only the EOB.
- `huffman_start` while not IDLE is held in a one-deep pending flag together with its eof; a further start while pending is dropped.
- Reset: all outputs 0, state IDLE, prev_dc 0, pending cleared. Reset mid-block abandons the block with no `block_done`.

## Timing
- Registered outputs: `sym_*`, `block_done`, `eof_out`.
- `zig_zag_rd_en` is combinational from state and `halt` and must never be high while `halt` is high.
- Read latency: RAM data arrives one cycle after `rd_en`, captured in CAP.
- Zero AC coefficient costs 3 cycles (RD, CAP, DEC).
- Nonzero AC coefficient costs 4 cycles minimum (RD, CAP, DEC, EMIT with immediate ready). Each ZRL adds 2 cycles (EMIT, DEC).
- `huffman_start` to the first `zig_zag_rd_en`: 1 cycle. A `halt` stall extends RD one cycle per high cycle.
- `block_done` is asserted the cycle after the final symbol handshake.

## Structure
- Shared package `jpeg_pkg`:
  - BLOCK_LEN=64.
  - ZRL_RUN=15.
  - Symbol-field widths.
  - Symbol struct typedef {dc, run, size, amp}.
- Sub-module `rle_size_amp`: combinational size priority encoder and amplitude mapper on a COEF_W+1 signed input. It is shared with the Huffman stage.

## Test plan
- DC-only block: coef[0]=5, rest 0, prev_dc=0. Required symbols:
  - DC size 3, amp 5.
  - EOB.
  - Then `block_done`.
- Second block with coef[0]=2: DC diff −3, size 2, amp 0b00. Then an eof block: `eof_out` fires and the next block's DC is taken against 0.
- AC runs:
  - coef[1]=−1 gives run 0, size 1, amp 0.
  - coef[20]=7 gives run 18, which must emit ZRL then run 2, size 3, amp 7.
  - Then EOB.
- Full block: coef[63]=1, all other AC 0. Required symbols:
  - ZRL ×3.
  - run 14, size 1, amp 1.
  - No EOB.
- Halt: `halt` high for 4 cycles during RD. `zig_zag_rd_en` stays low throughout, address is unchanged, and the output stream is identical to the unstalled run.
- Backpressure/reset: `sym_ready` is toggled randomly and the fields stay stable while unaccepted. A `huffman_start` mid-block starts the pending block after FIN. Asserting `rst` mid-block zeroes all outputs immediately.
